// File: rtl/vxe_cu_cmd_dispatch_pkg.sv
// Shared definitions for the CU command dispatch stage.
// Covers the command word layout, the opcodes, the activation codes and the FSM encoding.
package vxe_cu_cmd_dispatch_pkg;

  // Command word: op[63:59] | dst[58:48] | pl[47:0]
  // dst: bcast[10] | vpu index[9:3] | thread[2:0]
  localparam int CMD_W      = 64;
  localparam int OP_MSB     = 63;
  localparam int OP_LSB     = 59;
  localparam int DST_MSB    = 58;
  localparam int DST_LSB    = 48;
  localparam int TH_MSB     = 50;
  localparam int TH_LSB     = 48;
  localparam int PL_MSB     = 47;
  localparam int PL_LSB     = 0;
  localparam int DST_BCAST  = 10;
  localparam int DST_VPU_MSB = 9;
  localparam int DST_VPU_LSB = 3;
  localparam int SYNC_STOP_BIT = 0;
  localparam int SYNC_INTR_BIT = 1;

  localparam logic [4:0] CU_CMD_NOP    = 5'h00;
  localparam logic [4:0] CU_CMD_SYNC   = 5'h01;
  localparam logic [4:0] VPU_CMD_SETVL = 5'h08;
  localparam logic [4:0] VPU_CMD_LOAD  = 5'h09;
  localparam logic [4:0] VPU_CMD_STORE = 5'h0A;
  localparam logic [4:0] VPU_CMD_PROD  = 5'h0B;
  localparam logic [4:0] VPU_CMD_ADD   = 5'h0C;
  localparam logic [4:0] VPU_CMD_ACT   = 5'h0D;

  // Activation function codes carried in pl[2:0] of an ACT command
  localparam logic [2:0] ACTF_NONE = 3'd0;
  localparam logic [2:0] ACTF_RELU = 3'd1;
  localparam logic [2:0] ACTF_SIGM = 3'd2;
  localparam logic [2:0] ACTF_TANH = 3'd3;

  localparam logic [2:0] ST_STOP  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_DISP  = 3'd3;
  localparam logic [2:0] ST_SYNC  = 3'd4;

  typedef enum logic [1:0] {
    CMD_CLS_NOP,
    CMD_CLS_SYNC,
    CMD_CLS_VPU
  } cmd_cls_e;

endpackage

// File: rtl/vxe_cu_cmd_decoder.sv
// Combinational CU command decoder: classifies a command word, builds the VPU target mask
// and flags illegal opcodes, out-of-range targets and (optionally) malformed fields.
module vxe_cu_cmd_decoder
  import vxe_cu_cmd_dispatch_pkg::*;
#(
  parameter int VPUS_NR    = 2,
  parameter int VERIFY_FMT = 1
) (
  input  logic [CMD_W-1:0]   cmd,
  output logic               dec_err,
  output cmd_cls_e           cls,
  output logic [VPUS_NR-1:0] vpu_mask
);

  logic [4:0]  op;
  logic [10:0] dst;
  logic [47:0] pl;
  logic [6:0]  vpu_idx;
  logic        op_ok;
  logic        dst_ok;
  logic        fmt_ok;

  assign op      = cmd[OP_MSB:OP_LSB];
  assign dst     = cmd[DST_MSB:DST_LSB];
  assign pl      = cmd[PL_MSB:PL_LSB];
  assign vpu_idx = dst[DST_VPU_MSB:DST_VPU_LSB];

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    cls      = CMD_CLS_NOP;
    op_ok    = 1'b1;
    dst_ok   = 1'b1;
    fmt_ok   = 1'b1;
    vpu_mask = '0;
    case (op)
      CU_CMD_NOP: begin
        fmt_ok = (dst == '0) && (pl == '0);
      end
      CU_CMD_SYNC: begin
        cls    = CMD_CLS_SYNC;
        fmt_ok = (dst == '0) && (pl[47:2] == '0);
      end
      VPU_CMD_SETVL, VPU_CMD_LOAD, VPU_CMD_STORE, VPU_CMD_PROD, VPU_CMD_ADD: begin
        cls = CMD_CLS_VPU;
      end
      VPU_CMD_ACT: begin
        cls    = CMD_CLS_VPU;
        fmt_ok = (pl[2:0] <= ACTF_TANH);
      end
      default: op_ok = 1'b0;
    endcase

    // A unicast to a VPU that does not exist is always fatal: it would have no receiver.
    if (cls == CMD_CLS_VPU) begin
      dst_ok = dst[DST_BCAST] || ({25'd0, vpu_idx} < 32'(VPUS_NR));
      for (int i = 0; i < VPUS_NR; i++) begin
        vpu_mask[i] = dst[DST_BCAST] || (vpu_idx == 7'(i));
      end
    end

    dec_err = !op_ok || !dst_ok || ((VERIFY_FMT != 0) && !fmt_ok);
  end

endmodule

// File: rtl/vxe_cu_cmd_dispatch.sv
// CU execution stage: pops command words, runs NOP/SYNC locally and hands VPU commands
// to the targeted VPUs, tracking outstanding per-VPU handshakes until all are accepted.
module vxe_cu_cmd_dispatch
  import vxe_cu_cmd_dispatch_pkg::*;
#(
  parameter int VPUS_NR    = 2,
  parameter int VERIFY_FMT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [63:0]        i_cmd_data,
  input  logic               i_cmd_vld,
  output logic               o_cmd_rd,
  output logic [VPUS_NR-1:0] o_vpu_cmd_vld,
  input  logic [VPUS_NR-1:0] i_vpu_cmd_rdy,
  output logic [4:0]         o_vpu_cmd_op,
  output logic [2:0]         o_vpu_cmd_th,
  output logic [47:0]        o_vpu_cmd_pl,
  input  logic [VPUS_NR-1:0] i_vpu_busy,
  output logic               o_busy,
  output logic               o_intr,
  output logic               o_err,
  output logic [63:0]        o_err_cmd
);

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic [63:0]        cmd_q;
  logic [VPUS_NR-1:0] pend_q;
  logic [VPUS_NR-1:0] pend_left;
  logic               err_q;
  logic [63:0]        err_cmd_q;
  logic               vpu_idle;

  logic               dec_err;
  cmd_cls_e           dec_cls;
  logic [VPUS_NR-1:0] dec_mask;

  vxe_cu_cmd_decoder #(
    .VPUS_NR    (VPUS_NR),
    .VERIFY_FMT (VERIFY_FMT)
  ) u_decoder (
    .cmd      (cmd_q),
    .dec_err  (dec_err),
    .cls      (dec_cls),
    .vpu_mask (dec_mask)
  );

  // Targets still owed the command after this cycle's handshakes
  assign pend_left = pend_q & ~i_vpu_cmd_rdy;
  assign vpu_idle  = ~|i_vpu_busy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP:  if (i_start) state_d = ST_FETCH;
      ST_FETCH: if (i_cmd_vld) state_d = ST_EXEC;
      ST_EXEC: begin
        if (dec_err) begin
          state_d = ST_STOP;
        end else begin
          case (dec_cls)
            CMD_CLS_NOP:  state_d = ST_FETCH;
            CMD_CLS_SYNC: state_d = ST_SYNC;
            default:      state_d = ST_DISP;
          endcase
        end
      end
      ST_DISP:  if (pend_left == '0) state_d = ST_FETCH;
      ST_SYNC:  if (vpu_idle) state_d = cmd_q[SYNC_STOP_BIT] ? ST_STOP : ST_FETCH;
      default:  state_d = ST_STOP;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STOP;
      cmd_q     <= '0;
      pend_q    <= '0;
      err_q     <= 1'b0;
      err_cmd_q <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == ST_FETCH && i_cmd_vld) cmd_q <= i_cmd_data;

      if (state_q == ST_EXEC && !dec_err && dec_cls == CMD_CLS_VPU) begin
        pend_q <= dec_mask;
      end else if (state_q == ST_DISP) begin
        pend_q <= pend_left;
      end

      if (state_q == ST_STOP && i_start) begin
        err_q     <= 1'b0;
        err_cmd_q <= '0;
      end else if (state_q == ST_EXEC && dec_err) begin
        err_q     <= 1'b1;
        err_cmd_q <= cmd_q;
      end
    end
  end

  assign o_busy        = (state_q != ST_STOP);
  assign o_cmd_rd      = (state_q == ST_FETCH) && i_cmd_vld;
  assign o_vpu_cmd_vld = (state_q == ST_DISP) ? pend_q : '0;
  assign o_vpu_cmd_op  = cmd_q[OP_MSB:OP_LSB];
  assign o_vpu_cmd_th  = cmd_q[TH_MSB:TH_LSB];
  assign o_vpu_cmd_pl  = cmd_q[PL_MSB:PL_LSB];
  assign o_intr        = (state_q == ST_SYNC) && vpu_idle && cmd_q[SYNC_INTR_BIT];
  assign o_err         = err_q;
  assign o_err_cmd     = err_cmd_q;

endmodule

// File: tb/tb_vxe_cu_cmd_dispatch.sv
// Bench for vxe_cu_cmd_dispatch: directed scenarios with literal expectations, then random
// traffic checked every cycle against a command-level reference model.
module tb_vxe_cu_cmd_dispatch;

  localparam int NR = 2;
  localparam logic [63:0] W_PROD1    = 64'h5808_0000_0000_0000;
  localparam logic [63:0] W_PROD0    = 64'h5800_0000_0000_0000;
  localparam logic [63:0] W_SETVL_BC = 64'h4400_0000_0000_0100;
  localparam logic [63:0] W_SYNC3    = 64'h0800_0000_0000_0003;
  localparam logic [63:0] W_BADOP    = 64'hF800_0000_0000_0000;
  localparam logic [63:0] W_BADVPU   = 64'h5828_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [63:0]   i_cmd_data = '0;
  logic          i_cmd_vld = 1'b0;
  logic          o_cmd_rd;
  logic [NR-1:0] o_vpu_cmd_vld;
  logic [NR-1:0] i_vpu_cmd_rdy = '0;
  logic [4:0]    o_vpu_cmd_op;
  logic [2:0]    o_vpu_cmd_th;
  logic [47:0]   o_vpu_cmd_pl;
  logic [NR-1:0] i_vpu_busy = '0;
  logic          o_busy;
  logic          o_intr;
  logic          o_err;
  logic [63:0]   o_err_cmd;

  vxe_cu_cmd_dispatch #(.VPUS_NR(NR), .VERIFY_FMT(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_cmd_data    (i_cmd_data),
    .i_cmd_vld     (i_cmd_vld),
    .o_cmd_rd      (o_cmd_rd),
    .o_vpu_cmd_vld (o_vpu_cmd_vld),
    .i_vpu_cmd_rdy (i_vpu_cmd_rdy),
    .o_vpu_cmd_op  (o_vpu_cmd_op),
    .o_vpu_cmd_th  (o_vpu_cmd_th),
    .o_vpu_cmd_pl  (o_vpu_cmd_pl),
    .i_vpu_busy    (i_vpu_busy),
    .o_busy        (o_busy),
    .o_intr        (o_intr),
    .o_err         (o_err),
    .o_err_cmd     (o_err_cmd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_STOP, M_FETCH, M_EXEC, M_DISP, M_SYNC} mode_e;
  typedef enum {K_NOP, K_SYNC, K_VPU} kind_e;

  logic [63:0] fifo[$];
  mode_e       m_mode;
  logic [63:0] m_cmd;
  bit          m_owed[NR];
  bit          m_err;
  logic [63:0] m_err_cmd;
  int          m_acc[NR];
  int          dut_acc[NR];

  function automatic void ref_decode(input logic [63:0] w, output bit err, output kind_e kind,
                                     output bit owed[NR]);
    int     op;
    int     dst;
    int     vpu;
    bit     bcast;
    longint pl;
    op    = int'(w >> 59);
    dst   = int'((w >> 48) & 64'h7FF);
    pl    = longint'(w & 64'h0000_FFFF_FFFF_FFFF);
    vpu   = (dst / 8) % 128;
    bcast = (dst >= 1024);
    err   = 1'b0;
    kind  = K_VPU;
    for (int i = 0; i < NR; i++) owed[i] = 1'b0;
    if (op == 0) begin
      kind = K_NOP;
      err  = (dst != 0) || (pl != 0);
    end else if (op == 1) begin
      kind = K_SYNC;
      err  = (dst != 0) || (pl > 3);
    end else if (op >= 8 && op <= 13) begin
      err = !bcast && (vpu >= NR);
      if (op == 13 && (pl % 8) >= 4) err = 1'b1;
      for (int i = 0; i < NR; i++) owed[i] = bcast || (vpu == i);
    end else begin
      err = 1'b1;
    end
  endfunction

  task automatic model_reset();
    m_mode    = M_STOP;
    m_cmd     = '0;
    m_err     = 1'b0;
    m_err_cmd = '0;
    for (int i = 0; i < NR; i++) m_owed[i] = 1'b0;
  endtask

  task automatic step_model();
    bit    e;
    kind_e k;
    bit    any;
    case (m_mode)
      M_STOP: if (i_start) begin
        m_err = 1'b0; m_err_cmd = '0; m_mode = M_FETCH;
      end
      M_FETCH: if (fifo.size() != 0) begin
        m_cmd = fifo[0]; m_mode = M_EXEC;
      end
      M_EXEC: begin
        ref_decode(m_cmd, e, k, m_owed);
        if (e) begin
          m_err = 1'b1; m_err_cmd = m_cmd; m_mode = M_STOP;
          for (int i = 0; i < NR; i++) m_owed[i] = 1'b0;
        end else if (k == K_NOP)  m_mode = M_FETCH;
        else if (k == K_SYNC)     m_mode = M_SYNC;
        else                      m_mode = M_DISP;
      end
      M_DISP: begin
        any = 1'b0;
        for (int i = 0; i < NR; i++) begin
          if (m_owed[i] && i_vpu_cmd_rdy[i]) begin
            m_owed[i] = 1'b0;
            m_acc[i]++;
          end
          any |= m_owed[i];
        end
        if (!any) m_mode = M_FETCH;
      end
      M_SYNC: if (i_vpu_busy == '0) m_mode = m_cmd[0] ? M_STOP : M_FETCH;
      default: m_mode = M_STOP;
    endcase
  endtask

  task automatic compare();
    logic [NR-1:0] exp_vld;
    for (int i = 0; i < NR; i++) exp_vld[i] = (m_mode == M_DISP) && m_owed[i];
    check("busy", 64'(o_busy), 64'(m_mode != M_STOP));
    check("cmd_rd", 64'(o_cmd_rd), 64'(m_mode == M_FETCH && fifo.size() != 0));
    check("vpu_vld", 64'(o_vpu_cmd_vld), 64'(exp_vld));
    check("intr", 64'(o_intr), 64'(m_mode == M_SYNC && i_vpu_busy == '0 && m_cmd[1]));
    check("err", 64'(o_err), 64'(m_err));
    check("err_cmd", o_err_cmd, m_err_cmd);
    if (exp_vld != '0) begin
      check("vpu_op", 64'(o_vpu_cmd_op), m_cmd >> 59);
      check("vpu_th", 64'(o_vpu_cmd_th), (m_cmd >> 48) & 64'h7);
      check("vpu_pl", 64'(o_vpu_cmd_pl), m_cmd & 64'h0000_FFFF_FFFF_FFFF);
    end
  endtask

  // Drive inputs after the falling edge, then compare the settled outputs.
  task automatic drive(input bit st, input logic [NR-1:0] rdy, input logic [NR-1:0] bsy);
    @(negedge clk);
    i_start       = st;
    i_vpu_cmd_rdy = rdy;
    i_vpu_busy    = bsy;
    i_cmd_vld     = (fifo.size() != 0);
    i_cmd_data    = (fifo.size() != 0) ? fifo[0] : 64'h0;
    #1;
    compare();
  endtask

  task automatic advance();
    bit pop;
    step_model();
    for (int i = 0; i < NR; i++) if (o_vpu_cmd_vld[i] && i_vpu_cmd_rdy[i]) dut_acc[i]++;
    pop = o_cmd_rd;
    @(posedge clk);
    if (pop && fifo.size() != 0) void'(fifo.pop_front());
  endtask

  function automatic logic [63:0] rand_cmd();
    logic [4:0]  op;
    logic [10:0] dst;
    logic [47:0] pl;
    int          r;
    r   = $urandom_range(0, 15);
    op  = 5'h00;
    dst = '0;
    pl  = '0;
    if (r >= 2 && r < 4) begin
      op = 5'h01;
      pl = 48'($urandom_range(0, 3));
    end else if (r == 4) begin
      case ($urandom_range(0, 4))
        0:       op = 5'h1F;
        1:       begin op = 5'h0B; dst = 11'h028; end
        2:       begin op = 5'h01; pl = 48'h20; end
        3:       begin op = 5'h0D; pl = 48'h6; end
        default: pl = 48'h1;
      endcase
    end else if (r > 4) begin
      op  = 5'($urandom_range(8, 13));
      dst = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 1)), 3'($urandom)};
      pl  = {16'($urandom), 32'($urandom)};
    end
    return {op, dst, pl};
  endfunction

  initial begin
    bit            st;
    logic [NR-1:0] rdy;
    logic [NR-1:0] bsy;
    model_reset();
    for (int i = 0; i < NR; i++) begin m_acc[i] = 0; dut_acc[i] = 0; end

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_vld", 64'(o_vpu_cmd_vld), 64'd0);
    check("rst_err_cmd", o_err_cmd, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // NOP: pop, execute, back in FETCH two cycles later
    fifo.push_back(64'h0);
    drive(1, 2'b00, 2'b00); check("t1_stop_busy", 64'(o_busy), 64'd0); advance();
    drive(0, 2'b00, 2'b00); check("t1_pop", 64'(o_cmd_rd), 64'd1); advance();
    drive(0, 2'b00, 2'b00); advance();
    drive(0, 2'b00, 2'b00);
    check("t1_fetch", 64'({o_busy, o_cmd_rd, o_vpu_cmd_vld}), 64'b1000); advance();

    // Unicast PROD to VPU1, target ready only in the 4th DISP cycle
    fifo.push_back(W_PROD1);
    drive(0, 2'b00, 2'b00); check("t2_pop", 64'(o_cmd_rd), 64'd1); advance();
    drive(0, 2'b00, 2'b00); advance();
    for (int c = 0; c < 4; c++) begin
      drive(0, (c == 3) ? 2'b10 : 2'b01, 2'b00);
      check("t2_vld", 64'(o_vpu_cmd_vld), 64'b10);
      if (c == 0) check("t2_fields", 64'({o_vpu_cmd_op, o_vpu_cmd_th, o_vpu_cmd_pl}),
                        64'({5'h0B, 3'd0, 48'd0}));
      advance();
    end

    // Broadcast SETVL: VPU0 takes it at once, VPU1 two cycles later
    fifo.push_back(W_SETVL_BC);
    drive(0, 2'b00, 2'b00); check("t2_vld_drop", 64'(o_vpu_cmd_vld), 64'd0); advance();
    drive(0, 2'b00, 2'b00); advance();
    drive(0, 2'b01, 2'b00); check("t3_vld0", 64'(o_vpu_cmd_vld), 64'b11); advance();
    drive(0, 2'b00, 2'b00); check("t3_vld1", 64'(o_vpu_cmd_vld), 64'b10); advance();
    drive(0, 2'b10, 2'b00); check("t3_vld2", 64'(o_vpu_cmd_vld), 64'b10);
    check("t3_pl", 64'(o_vpu_cmd_pl), 64'h100); advance();

    // SYNC with intr+stop, held by a busy VPU for 5 cycles
    fifo.push_back(W_SYNC3);
    fifo.push_back(64'h0);
    drive(0, 2'b00, 2'b00); check("t3_done", 64'(o_vpu_cmd_vld), 64'd0); advance();
    drive(0, 2'b00, 2'b00); advance();
    for (int c = 0; c < 5; c++) begin
      drive(0, 2'b00, 2'b01); check("t4_wait", 64'({o_busy, o_intr}), 64'b10); advance();
    end
    drive(0, 2'b00, 2'b00); check("t4_intr", 64'(o_intr), 64'd1); advance();
    drive(0, 2'b00, 2'b00);
    check("t4_stopped", 64'({o_busy, o_intr, o_cmd_rd}), 64'b000); advance();

    // Illegal opcode, then an out-of-range unicast target
    fifo.push_back(W_BADOP);
    drive(1, 2'b00, 2'b00); advance();
    repeat (4) begin drive(0, 2'b00, 2'b00); advance(); end
    drive(0, 2'b00, 2'b00);
    check("t5_err", 64'({o_err, o_busy}), 64'b10);
    check("t5_err_cmd", o_err_cmd, W_BADOP); advance();
    fifo.push_back(W_BADVPU);
    drive(1, 2'b00, 2'b00); check("t5_err_held", 64'(o_err), 64'd1); advance();
    drive(0, 2'b00, 2'b00); check("t5_err_clr", 64'(o_err), 64'd0); advance();
    drive(0, 2'b00, 2'b00); advance();
    drive(0, 2'b00, 2'b00);
    check("t5_err2", 64'(o_err), 64'd1);
    check("t5_err_cmd2", o_err_cmd, W_BADVPU); advance();

    // Reset asserted in the middle of a dispatch
    fifo.push_back(W_PROD0);
    drive(1, 2'b00, 2'b00); advance();
    drive(0, 2'b00, 2'b00); advance();
    drive(0, 2'b00, 2'b00); advance();
    drive(0, 2'b00, 2'b00); check("t6_disp", 64'(o_vpu_cmd_vld), 64'b01);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_out", 64'({o_busy, o_vpu_cmd_vld, o_intr, o_err, o_cmd_rd}), 64'd0);
    check("t6_rst_fields", 64'({o_vpu_cmd_op, o_vpu_cmd_th, o_vpu_cmd_pl}), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      if (fifo.size() < 4 && $urandom_range(0, 1) == 1) fifo.push_back(rand_cmd());
      st  = (m_mode == M_STOP) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      rdy = NR'($urandom);
      bsy = {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
      drive(st, rdy, bsy);
      advance();
    end

    for (int i = 0; i < NR; i++) check("vpu_accept_count", 64'(dut_acc[i]), 64'(m_acc[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
